stream_cipher_core: RTL and testbench
=====================================

// Module: stream_cipher_core
// PURPOSE
//   Iterative, keyed, multi-round byte/word cipher engine that supersedes the fixed 8-bit combinational decrypt.
//   It performs encrypt or decrypt per transaction, chosen by a mode bit, and computes one round per clock.
//   Valid/ready handshakes on input and output let it sit directly in the streaming datapath between the host interface and the hash/keyed blocks.
// PARAMETERS
//   DATA_W      8     data and key width in bits (>=2)
//   ROUNDS      4     round count per transaction (>=1)
//   ROUND_CONST 8'h5A additive round constant; the low DATA_W bits are used
// PORTS
//   clk       in  1       clock, rising edge
//   rst_n     in  1       asynchronous active-low reset
//   in_valid  in  1       input word/key/mode valid
//   in_ready  out 1       engine can accept an input
//   in_data   in  DATA_W  plaintext (mode=0) or ciphertext (mode=1)
//   in_key    in  DATA_W  key for this transaction
//   in_mode   in  1       0 = encrypt, 1 = decrypt
//   out_valid out 1       result valid
//   out_ready in  1       downstream accepts the result
//   out_data  out DATA_W  result word
//   busy      out 1       high in RUN or DONE
// BEHAVIOUR
//   Arithmetic: all operations are modulo 2^DATA_W. rotl1/rotr1 rotate by 1 bit.
//     Round key: k_r = rotl(key, r mod DATA_W). C = ROUND_CONST[DATA_W-1:0].
//   Encrypt rounds, r = 0..ROUNDS-1:       x <= rotl1(x ^ k_r) + C
//   Decrypt rounds, r = ROUNDS-1 down to 0: x <= rotr1(x - C) ^ k_r
//     decrypt(encrypt(p,k),k) == p for all p and k.
//   FSM states: IDLE, RUN, DONE.
//     IDLE: in_ready=1. On in_valid&&in_ready, capture data, key and mode.
//       Round counter loads 0 for encrypt or ROUNDS-1 for decrypt. Next state RUN.
//     RUN: applies one round per edge; the counter increments (enc) or decrements (dec).
//       After the ROUNDS-th round, next state is DONE.
//     DONE: out_valid=1 and out_data holds the result. On out_ready, next state is IDLE.
//   Latency: out_valid rises exactly ROUNDS clock edges after the accept edge.
//     Throughput is one transaction per ROUNDS+2 cycles when out_ready is held high.
//   in_ready is 0 in RUN and DONE. Inputs in those states are ignored, and captured values are unaffected by input changes after accept.
//   Backpressure: while out_valid=1 and out_ready=0, out_data stays stable and no new input is accepted.
//   Simultaneous out handshake and in_valid in DONE: the result is consumed and the input is NOT accepted that cycle.
//     The input is accepted in the following IDLE cycle.
//   Reset (any time, including mid-RUN): state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0.
//     The internal data, key, mode and counter registers reset to 0, and the in-flight transaction is discarded.
//   in_ready is asserted during reset; reset deassertion must be synchronised upstream.
//   in_ready, out_valid and busy are decoded directly from state registers (no combinational path from in_valid or out_ready).
// TESTING (DATA_W=8, ROUNDS=4, ROUND_CONST=8'h5A unless stated)
//   1. Encrypt data=00, key=00 -> out_data=46, out_valid 4 edges after accept.
//   2. Encrypt data=41, key=01 -> 3A. Decrypt data=3A, key=01 -> 41.
//   3. ROUNDS=1: encrypt 00/key 00 -> 5A. Decrypt 5A/key 00 -> 00.
//   4. Hold out_ready=0 for 10 cycles in DONE, toggling in_* each cycle.
//        out_data stays stable, in_ready=0, and out_ready=1 completes exactly one transfer.
//   5. Assert rst_n=0 mid-RUN (after 2 rounds) -> all outputs reach reset values immediately.
//        A fresh encrypt of 00/key 00 then returns 46.
//   6. Random p, key, mode for 1000 transactions with random out_ready.
//        Each encrypt-then-decrypt round trip returns p, and no transaction is lost or duplicated.

Source files
------------

// File: rtl/stream_cipher_core.sv
`default_nettype none
// ============================================================================
// Module   : stream_cipher_core
// Purpose  : Iterative keyed cipher; one encrypt/decrypt round per clock.
// Revision : 1.0
// ============================================================================
module stream_cipher_core #(
  parameter int          DATA_W      = 8,
  parameter int          ROUNDS      = 4,
  parameter logic [31:0] ROUND_CONST = 32'h5A
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_key,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int                c_cnt_w    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(ROUNDS - 1);
  localparam logic [DATA_W-1:0] c_rc       = DATA_W'(ROUND_CONST);
  localparam logic [31:0]       c_dw       = 32'(DATA_W);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]          r_state;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_key;
  logic                r_mode;
  logic [c_cnt_w-1:0]  r_round;

  logic [31:0]         w_rot_amt;
  logic [2*DATA_W-1:0] w_key_dbl;
  logic [DATA_W-1:0]   w_round_key;
  logic [DATA_W-1:0]   w_enc_mix;
  logic [DATA_W-1:0]   w_enc_next;
  logic [DATA_W-1:0]   w_dec_sub;
  logic [DATA_W-1:0]   w_dec_next;
  logic [DATA_W-1:0]   w_next;
  logic                w_last;

  always_comb begin
    // Upper half of the doubled key shifted left is the key rotated left.
    w_rot_amt   = 32'(r_round) % c_dw;
    w_key_dbl   = {r_key, r_key} << w_rot_amt;
    w_round_key = w_key_dbl[2*DATA_W-1:DATA_W];
    w_enc_mix   = r_data ^ w_round_key;
    w_enc_next  = {w_enc_mix[DATA_W-2:0], w_enc_mix[DATA_W-1]} + c_rc;
    w_dec_sub   = r_data - c_rc;
    w_dec_next  = {w_dec_sub[0], w_dec_sub[DATA_W-1:1]} ^ w_round_key;
    w_next      = r_mode ? w_dec_next : w_enc_next;
    w_last      = r_mode ? (r_round == '0) : (r_round == c_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_data  <= '0;
      r_key   <= '0;
      r_mode  <= 1'b0;
      r_round <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            r_data  <= in_data;
            r_key   <= in_key;
            r_mode  <= in_mode;
            r_round <= in_mode ? c_last : '0;
            r_state <= c_st_run;
          end
        end
        c_st_run: begin
          r_data <= w_next;
          if (w_last) begin
            r_state <= c_st_done;
          end else begin
            r_round <= r_mode ? (r_round - c_cnt_w'(1)) : (r_round + c_cnt_w'(1));
          end
        end
        c_st_done: begin
          if (out_ready) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  // Handshake flags come straight from state so no input-to-output paths exist.
  assign in_ready  = (r_state == c_st_idle);
  assign out_valid = (r_state == c_st_done);
  assign busy      = (r_state == c_st_run) || (r_state == c_st_done);
  assign out_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_stream_cipher_core.sv
`default_nettype none
// Testbench for stream_cipher_core: vector table, corner sequences, and a
// randomized round-trip scoreboard against a reference cipher model.
module tb_stream_cipher_core;

  localparam int          R  = 4;
  localparam logic [7:0]  RC = 8'h5A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, in_ready, in_mode = 1'b0, out_valid, out_ready = 1'b0, busy;
  logic [7:0] in_data = '0, in_key = '0, out_data;
  logic       b_in_valid = 1'b0, b_in_ready, b_in_mode = 1'b0, b_out_valid, b_out_ready = 1'b0, b_busy;
  logic [7:0] b_in_data = '0, b_in_key = '0, b_out_data;

  stream_cipher_core #(.DATA_W(8), .ROUNDS(4), .ROUND_CONST(32'h5A)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  stream_cipher_core #(.DATA_W(8), .ROUNDS(1), .ROUND_CONST(32'h5A)) u_dut_r1 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_key(b_in_key), .in_mode(b_in_mode), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference cipher written directly from the round equations.
  function automatic logic [7:0] rotl(input logic [7:0] v, input int s);
    int n;
    n = s % 8;
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] rotr(input logic [7:0] v, input int s);
    return rotl(v, 8 - (s % 8));
  endfunction

  function automatic logic [7:0] model(input logic mode, input logic [7:0] d,
                                       input logic [7:0] k, input int rounds);
    logic [7:0] x, t;
    x = d;
    if (!mode) begin
      for (int r = 0; r < rounds; r++) begin
        t = x ^ rotl(k, r);
        x = rotl(t, 1) + RC;
      end
    end else begin
      for (int r = rounds - 1; r >= 0; r--) begin
        t = x - RC;
        x = rotr(t, 1) ^ rotl(k, r);
      end
    end
    return x;
  endfunction

  // One complete transaction on the ROUNDS=4 instance; scrambles inputs after accept.
  task automatic run_txn(input logic m, input logic [7:0] d, input logic [7:0] k,
                         output logic [7:0] res, output int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_mode = m; in_data = d; in_key = k; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 8'($urandom); in_key = 8'($urandom); in_mode = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_data;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic b_txn(input string name, input logic m, input logic [7:0] d,
                       input logic [7:0] k, input logic [7:0] exp);
    @(negedge clk);
    b_in_valid = 1'b1; b_in_mode = m; b_in_data = d; b_in_key = k; b_out_ready = 1'b0;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    check({name, "_run_not_valid"}, b_out_valid, 1'b0);
    @(posedge clk); #1;
    check({name, "_valid"}, b_out_valid, 1'b1);
    check({name, "_data"}, b_out_data, exp);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    check({name, "_consumed"}, b_out_valid, 1'b0);
  endtask

  typedef struct {
    logic       mode;
    logic [7:0] data;
    logic [7:0] key;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic       mode;
    logic [7:0] data;
    logic [7:0] key;
    logic [7:0] exp;
    bit         seed;
  } txn_t;

  initial begin
    vec_t       vecs[4];
    logic [7:0] res;
    int         lat;
    txn_t       req_q[$];
    txn_t       exp_q[$];
    txn_t       t;
    int         received;
    int         cycles;

    vecs[0] = '{1'b0, 8'h00, 8'h00, 8'h46};
    vecs[1] = '{1'b0, 8'h41, 8'h01, 8'h3A};
    vecs[2] = '{1'b1, 8'h3A, 8'h01, 8'h41};
    vecs[3] = '{1'b1, 8'h46, 8'h00, 8'h00};

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_r1_in_ready", b_in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_txn(vecs[i].mode, vecs[i].data, vecs[i].key, res, lat);
      check($sformatf("vec%0d_data", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, R);
    end

    // Single-round instance
    b_txn("r1_enc", 1'b0, 8'h00, 8'h00, 8'h5A);
    b_txn("r1_dec", 1'b1, 8'h5A, 8'h00, 8'h00);
    check("r1_idle_busy", b_busy, 1'b0);

    // Backpressure in DONE with input churn
    @(negedge clk);
    in_valid = 1'b1; in_mode = 1'b0; in_data = 8'h41; in_key = 8'h01; out_ready = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      in_valid = 1'($urandom); in_data = 8'($urandom); in_key = 8'($urandom); in_mode = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", lat, R);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'($urandom); in_key = 8'($urandom); in_mode = 1'($urandom);
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_data", i), out_data, 8'h3A);
      check($sformatf("bp_hold%0d_in_ready", i), in_ready, 1'b0);
      check($sformatf("bp_hold%0d_valid", i), out_valid, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b1; in_mode = 1'b0; in_data = 8'h00; in_key = 8'h00; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_xfer_valid_low", out_valid, 1'b0);
    check("bp_not_accepted_busy", busy, 1'b0);
    check("bp_idle_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_accept_busy", busy, 1'b1);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_next_latency", lat, R);
    check("bp_next_data", out_data, 8'h46);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset after two rounds
    @(negedge clk);
    in_valid = 1'b1; in_mode = 1'b0; in_data = 8'h00; in_key = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_run_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_data", out_data, 8'h00);
    check("arst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 8'h00, 8'h00, res, lat);
    check("post_rst_data", res, 8'h46);
    check("post_rst_latency", lat, R);

    // Random round trips with random out_ready
    for (int i = 0; i < 500; i++) begin
      t.mode = 1'($urandom);
      t.data = 8'($urandom);
      t.key  = 8'($urandom);
      t.exp  = model(t.mode, t.data, t.key, R);
      t.seed = 1'b1;
      req_q.push_back(t);
    end
    received = 0;
    cycles = 0;
    while (received < 1000 && cycles < 40000) begin
      @(negedge clk);
      cycles++;
      out_ready = 1'($urandom);
      if (req_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_mode  = req_q[0].mode;
        in_data  = req_q[0].data;
        in_key   = req_q[0].key;
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(req_q.pop_front());
      end
      if (out_valid && out_ready) begin
        received++;
        if (exp_q.size() == 0) begin
          check("rand_unexpected_output", 1'b1, 1'b0);
        end else begin
          t = exp_q.pop_front();
          check($sformatf("rand%0d_data", received), out_data, t.exp);
          if (t.seed) begin
            req_q.push_back('{~t.mode, out_data, t.key, t.data, 1'b0});
          end
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("rand_received", received, 1000);
    check("rand_leftover", exp_q.size() + req_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
